// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_pkg
// Description : Shared definitions for the data-memory port. Holds the
//               responder state encoding, the latched request record and the
//               address error check. The core's MEM-state stall logic uses
//               the same error check.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

   localparam int unsigned WORD_BYTES   = 4;
   localparam int unsigned DMEM_STATE_W = 2;

   typedef logic [DMEM_STATE_W-1:0] dmem_state_t;

   localparam dmem_state_t DMEM_IDLE = 2'd0;
   localparam dmem_state_t DMEM_WAIT = 2'd1;
   localparam dmem_state_t DMEM_RESP = 2'd2;

   // Request fields captured at accept time
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   // A request is in error when the byte address is not word aligned, or the
   // word index (all upper bits, no truncation) is outside the array.
   function automatic logic dmem_addr_err(input logic [31:0] addr,
                                          input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Load/store request and response bundle between the core
//               (master) and the data-memory responder (slave).
// Ports       : req_valid/req_we/req_addr/req_wdata  master -> slave
//               req_ready                            slave  -> master
//               resp_valid/resp_rdata/resp_err       slave  -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Word storage, one synchronous write port, one combinational
//               read port (A) and one registered read port (B). Storage has
//               no reset.
// Ports       : clk              clock
//               i_we/i_waddr/i_wdata   write port, commits on rising edge
//               i_raddr_a/o_rdata_a    combinational read
//               i_raddr_b/o_rdata_b    registered read, one-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  wire logic          clk,
   input  wire logic          i_we,
   input  wire logic [AW-1:0] i_waddr,
   input  wire logic [31:0]   i_wdata,
   input  wire logic [AW-1:0] i_raddr_a,
   output logic [31:0]        o_rdata_a,
   input  wire logic [AW-1:0] i_raddr_b,
   output logic [31:0]        o_rdata_b
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata_b;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Port B samples the pre-write contents, so a same-edge commit to the same
   // word appears one cycle later.
   always_ff @(posedge clk) begin
      r_rdata_b <= r_mem[i_raddr_b];
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_rdata_b;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder. Accepts one load/store, waits LATENCY
//               cycles, returns one response beat, then commits stores on
//               the edge that leaves the response cycle.
// Ports       : clk        clock, rising edge
//               reset      asynchronous, active-low
//               bus        request/response bundle (slave side)
//               dbg_addr   debug word index
//               dbg_rdata  mem[dbg_addr], one-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   dmem_responder_if.slave               bus,
   input  wire logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [31:0]                   dbg_rdata
);

   localparam int unsigned c_aw       = $clog2(DEPTH);
   localparam logic [3:0]  c_cnt_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   dmem_state_t r_state;
   dmem_state_t w_state_next;
   logic [3:0]  r_cnt;
   dmem_req_t   r_req;
   logic        r_err;
   logic        r_resp_err;
   logic [31:0] r_resp_rdata;

   logic        w_accept;
   logic        w_mem_we;
   logic [31:0] w_rd_addr;
   logic [31:0] w_rdata_a;
   logic        w_req_err;
   logic        w_err_eff;
   logic        w_we_eff;

   assign w_accept  = (r_state == DMEM_IDLE) && bus.req_valid;

   // While idle the live bus fields are used so that a zero-latency request
   // can be answered on the cycle right after accept; afterwards only the
   // latched copy matters.
   assign w_rd_addr = (r_state == DMEM_IDLE) ? bus.req_addr : r_req.addr;
   assign w_req_err = dmem_addr_err(w_rd_addr, DEPTH);
   assign w_err_eff = (r_state == DMEM_IDLE) ? w_req_err  : r_err;
   assign w_we_eff  = (r_state == DMEM_IDLE) ? bus.req_we : r_req.we;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= DMEM_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         DMEM_IDLE: begin
            if (w_accept) begin
               w_state_next = (LATENCY == 0) ? DMEM_RESP : DMEM_WAIT;
            end
         end
         DMEM_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_next = DMEM_RESP;
            end
         end
         DMEM_RESP: w_state_next = DMEM_IDLE;
         default:   w_state_next = DMEM_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.req_ready  = (r_state == DMEM_IDLE);
      bus.resp_valid = (r_state == DMEM_RESP);
      bus.resp_rdata = r_resp_rdata;
      bus.resp_err   = r_resp_err;
      w_mem_we       = (r_state == DMEM_RESP) && r_req.we && !r_err;
   end

   // Request latch, wait counter and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req        <= '0;
         r_err        <= 1'b0;
         r_cnt        <= 4'd0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'd0;
      end else begin
         if (w_accept) begin
            r_req <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
            r_err <= w_req_err;
            r_cnt <= c_cnt_init;
         end else if ((r_state == DMEM_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end

         // Loaded on entry to RESP; no write can land between this sample
         // and the response cycle because only one request is in flight.
         if (w_state_next == DMEM_RESP) begin
            r_resp_err   <= w_err_eff;
            r_resp_rdata <= (w_err_eff || w_we_eff) ? 32'd0 : w_rdata_a;
         end else begin
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (c_aw)
   ) u_array (
      .clk       (clk),
      .i_we      (w_mem_we),
      .i_waddr   (r_req.addr[c_aw+1:2]),
      .i_wdata   (r_req.wdata),
      .i_raddr_a (w_rd_addr[c_aw+1:2]),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (dbg_addr),
      .o_rdata_b (dbg_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Bench for dmem_responder. Instance A uses LATENCY=2, instance
//               B uses LATENCY=0; both DEPTH=256. Expected responses are
//               queued when a request is issued and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [7:0]  dbg_addr_a;
   logic [7:0]  dbg_addr_b;
   logic [31:0] dbg_rdata_a;
   logic [31:0] dbg_rdata_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic mon_en   = 1'b0;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   acc_a[$];
   int   acc_b[$];
   int   acc_log_a[$];

   dmem_responder_if bus_a();
   dmem_responder_if bus_b();

   dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_a),
      .dbg_addr  (dbg_addr_a),
      .dbg_rdata (dbg_rdata_a)
   );

   dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_b),
      .dbg_addr  (dbg_addr_b),
      .dbg_rdata (dbg_rdata_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Monitor: logs accepts, pops and compares responses, checks idle zeros
   task automatic mon(input int sel, input logic rv, input logic [31:0] rd,
                      input logic re, input logic acc);
      exp_t e;
      int   a;
      int   lat;
      lat = (sel == 0) ? 2 : 0;
      if (acc) begin
         if (sel == 0) begin
            acc_a.push_back(cyc + 1);
            acc_log_a.push_back(cyc + 1);
         end else begin
            acc_b.push_back(cyc + 1);
         end
      end
      if (rv) begin
         if ((sel == 0 && (exp_a.size() == 0 || acc_a.size() == 0)) ||
             (sel == 1 && (exp_b.size() == 0 || acc_b.size() == 0))) begin
            check_eq("unexpected_resp", 32'd1, 32'd0);
         end else begin
            if (sel == 0) begin
               e = exp_a.pop_front();
               a = acc_a.pop_front();
            end else begin
               e = exp_b.pop_front();
               a = acc_b.pop_front();
            end
            check_eq(sel == 0 ? "a_rdata" : "b_rdata", rd, e.rdata);
            check_eq(sel == 0 ? "a_err" : "b_err", {31'd0, re}, {31'd0, e.err});
            check_eq(sel == 0 ? "a_latency" : "b_latency", 32'(cyc - a), 32'(lat));
         end
      end else begin
         check_eq(sel == 0 ? "a_idle_rdata" : "b_idle_rdata", rd, 32'd0);
         check_eq(sel == 0 ? "a_idle_err" : "b_idle_err", {31'd0, re}, 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, bus_a.resp_valid, bus_a.resp_rdata, bus_a.resp_err,
             bus_a.req_valid && bus_a.req_ready);
         mon(1, bus_b.resp_valid, bus_b.resp_rdata, bus_b.resp_err,
             bus_b.req_valid && bus_b.req_ready);
      end
   end

   task automatic set_req(input int sel, input logic v, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
      if (sel == 0) begin
         bus_a.req_valid = v; bus_a.req_we = we;
         bus_a.req_addr  = addr; bus_a.req_wdata = wdata;
      end else begin
         bus_b.req_valid = v; bus_b.req_we = we;
         bus_b.req_addr  = addr; bus_b.req_wdata = wdata;
      end
   endtask

   function automatic logic ready(input int sel);
      return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
   endfunction

   function automatic int qsize(input int sel);
      return (sel == 0) ? exp_a.size() : exp_b.size();
   endfunction

   task automatic push_exp(input int sel, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.rdata = rdata;
      e.err   = err;
      if (sel == 0) exp_a.push_back(e);
      else          exp_b.push_back(e);
   endtask

   // Returns at posedge+1 with ready high, i.e. the next edge accepts
   task automatic wait_ready(input int sel);
      int n = 0;
      while (!ready(sel) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check_eq("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
      push_exp(sel, exp_rdata, exp_err);
      @(posedge clk); #1;
      set_req(sel, 1'b1, we, addr, wdata);
      wait_ready(sel);
      @(posedge clk); #1;
      set_req(sel, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic drain(input int sel);
      int n = 0;
      while (qsize(sel) != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         check_eq("resp_timeout", 32'd0, 32'd1);
         if (sel == 0) begin exp_a.delete(); acc_a.delete(); end
         else          begin exp_b.delete(); acc_b.delete(); end
      end
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      dbg_addr_a = 8'd0;
      dbg_addr_b = 8'd0;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      #2 reset = 1'b0;
      #1;
      check_eq("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
      check_eq("rst_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
      check_eq("rst_resp_rdata", bus_a.resp_rdata, 32'd0);
      check_eq("rst_resp_err", {31'd0, bus_a.resp_err}, 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      mon_en = 1'b1;

      // Store then load the same word
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
      issue(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
      drain(0);

      // Debug port across a commit to the observed word
      dbg_addr_a = 8'd4;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("dbg_before", dbg_rdata_a, 32'hDEADBEEF);
      issue(0, 1'b1, 32'h10, 32'h55, 32'd0, 1'b0);
      n = 0;
      while (!bus_a.resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) check_eq("dbg_resp_timeout", 32'd0, 32'd1);
      check_eq("dbg_in_resp", dbg_rdata_a, 32'hDEADBEEF);
      @(posedge clk); #1;
      check_eq("dbg_commit_cycle", dbg_rdata_a, 32'hDEADBEEF);
      @(posedge clk); #1;
      check_eq("dbg_after", dbg_rdata_a, 32'h55);
      drain(0);

      // Error cases and boundary words
      issue(0, 1'b1, 32'h0,   32'h0BADF00D, 32'd0, 1'b0);
      issue(0, 1'b1, 32'h3FC, 32'h600DCAFE, 32'd0, 1'b0);
      issue(0, 1'b0, 32'h12,  32'd0, 32'd0, 1'b1);
      issue(0, 1'b1, 32'h400, 32'hFFFFFFFF, 32'd0, 1'b1);
      issue(0, 1'b1, 32'h80000000, 32'hEEEEEEEE, 32'd0, 1'b1);
      issue(0, 1'b0, 32'h80000010, 32'd0, 32'd0, 1'b1);
      issue(0, 1'b0, 32'h0,   32'd0, 32'h0BADF00D, 1'b0);
      issue(0, 1'b0, 32'h3FC, 32'd0, 32'h600DCAFE, 1'b0);
      drain(0);

      // Held request with fields changed while busy
      push_exp(0, 32'd0, 1'b0);
      push_exp(0, 32'h11111111, 1'b0);
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b1, 32'h40, 32'h11111111);
      wait_ready(0);
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 32'h40, 32'h99999999);
      wait_ready(0);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      if (acc_log_a.size() >= 2)
         check_eq("b2b_spacing",
                  32'(acc_log_a[acc_log_a.size()-1] - acc_log_a[acc_log_a.size()-2]), 32'd4);
      else
         check_eq("b2b_accepts", 32'(acc_log_a.size()), 32'd2);
      drain(0);

      // Reset during WAIT of a store drops it
      issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
      drain(0);
      push_exp(0, 32'd0, 1'b0);
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
      wait_ready(0);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_eq("wait_not_ready", {31'd0, bus_a.req_ready}, 32'd0);
      #2 reset = 1'b0;
      #1;
      check_eq("async_rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
      check_eq("async_rst_valid", {31'd0, bus_a.resp_valid}, 32'd0);
      check_eq("async_rst_rdata", bus_a.resp_rdata, 32'd0);
      check_eq("async_rst_err", {31'd0, bus_a.resp_err}, 32'd0);
      if (exp_a.size() != 0) void'(exp_a.pop_front());
      if (acc_a.size() != 0) void'(acc_a.pop_front());
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      issue(0, 1'b0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);
      drain(0);

      // Zero-latency instance, highest legal word and first illegal word
      issue(1, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'd0, 1'b0);
      issue(1, 1'b0, 32'h3FC, 32'd0, 32'hA5A5A5A5, 1'b0);
      issue(1, 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
      drain(1);

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
